// File: rtl/pmips_branch_predictor.sv
// rtl/pmips_branch_predictor.sv - direct-mapped BTB with per-entry direction counters and optional gshare indexing
module pmips_branch_predictor #(
    parameter int ADDR_W    = 16,
    parameter int ENTRIES   = 16,
    parameter int INDEX_LSB = 1,
    parameter int MODE      = 2,
    parameter int GHR_W     = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              predict_hit,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_predicted,
    output logic [CNT_W-1:0]  lookup_count,
    output logic [CNT_W-1:0]  mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - INDEX_LSB - IDX_W;
    localparam int GH_W  = (GHR_W > 0) ? GHR_W : 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [GH_W-1:0]    ghr_q, ghr_d;
    logic [CNT_W-1:0]   lookup_count_q, lookup_count_d;
    logic [CNT_W-1:0]   mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] ghr_idx;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    // Same history value folds into both lookup and update index within a cycle.
    generate
        if (GHR_W == 0) begin : g_bimodal
            assign ghr_idx = '0;
            assign ghr_d   = '0;
        end else if (GHR_W == 1) begin : g_ghr1
            assign ghr_idx = IDX_W'(ghr_q);
            assign ghr_d   = update_valid ? update_taken : ghr_q;
        end else begin : g_ghrn
            assign ghr_idx = IDX_W'(ghr_q);
            assign ghr_d   = update_valid ? {ghr_q[GHR_W-2:0], update_taken} : ghr_q;
        end
    endgenerate

    assign lk_idx = lookup_pc[INDEX_LSB +: IDX_W] ^ ghr_idx;
    assign up_idx = update_pc[INDEX_LSB +: IDX_W] ^ ghr_idx;
    assign lk_tag = lookup_pc[ADDR_W-1 -: TAG_W];
    assign up_tag = update_pc[ADDR_W-1 -: TAG_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads registered state only, so a same-cycle update is not visible.
    always_comb begin
        predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_taken  = (MODE != 0) && predict_hit && ctr_q[lk_idx][1];
        predict_target = predict_hit ? target_q[lk_idx] : '0;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (update_valid) begin
            if (up_hit) begin
                if (MODE == 2) begin
                    if (update_taken && ctr_q[up_idx] != 2'b11)
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    else if (!update_taken && ctr_q[up_idx] != 2'b00)
                        ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end else if (MODE == 1) begin
                    ctr_d[up_idx] = update_taken ? 2'b11 : 2'b00;
                end
                if (update_taken)
                    target_d[up_idx] = update_target;
            end else if (update_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target;
                ctr_d[up_idx]    = (MODE == 2) ? 2'b10 : 2'b11;
            end
        end
    end

    always_comb begin
        lookup_count_d = lookup_count_q;
        if (lookup_valid && lookup_count_q != '1)
            lookup_count_d = lookup_count_q + CNT_W'(1);
        mispredict_count_d = mispredict_count_q;
        if (update_valid && (update_predicted != update_taken) && mispredict_count_q != '1)
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q            <= '0;
            ghr_q              <= '0;
            lookup_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            ghr_q              <= ghr_d;
            lookup_count_q     <= lookup_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign lookup_count     = lookup_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_pmips_branch_predictor.sv
// tb/tb_pmips_branch_predictor.sv - directed checks for pmips_branch_predictor across MODE and GHR_W variants
module tb_pmips_branch_predictor;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [15:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [15:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [15:0] update_target = '0;
    logic        update_predicted = 1'b0;

    logic        hit, taken;
    logic [15:0] target;
    logic [3:0]  lcnt, mcnt;
    logic        m0_hit, m0_taken;
    logic [15:0] m0_target;
    logic [3:0]  m0_lcnt, m0_mcnt;
    logic        g_hit, g_taken;
    logic [15:0] g_target;
    logic [3:0]  g_lcnt, g_mcnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pmips_branch_predictor #(.ADDR_W(16), .ENTRIES(16), .INDEX_LSB(1), .MODE(2), .GHR_W(0), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_hit(hit), .predict_taken(taken), .predict_target(target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted(update_predicted),
        .lookup_count(lcnt), .mispredict_count(mcnt));

    pmips_branch_predictor #(.ADDR_W(16), .ENTRIES(16), .INDEX_LSB(1), .MODE(0), .GHR_W(0), .CNT_W(4)) dut_m0 (
        .clock(clock), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_hit(m0_hit), .predict_taken(m0_taken), .predict_target(m0_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted(update_predicted),
        .lookup_count(m0_lcnt), .mispredict_count(m0_mcnt));

    pmips_branch_predictor #(.ADDR_W(16), .ENTRIES(16), .INDEX_LSB(1), .MODE(2), .GHR_W(2), .CNT_W(4)) dut_g (
        .clock(clock), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_hit(g_hit), .predict_taken(g_taken), .predict_target(g_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted(update_predicted),
        .lookup_count(g_lcnt), .mispredict_count(g_mcnt));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt, input logic pred);
        update_valid     = 1'b1;
        update_pc        = pc;
        update_taken     = tk;
        update_target    = tgt;
        update_predicted = pred;
        tick();
        update_valid     = 1'b0;
    endtask

    task automatic look(input logic [15:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        // An update coinciding with reset must be dropped.
        reset = 1'b1;
        update_valid = 1'b1; update_pc = 16'h0040; update_taken = 1'b1; update_target = 16'h0010;
        lookup_valid = 1'b1;
        tick();
        reset = 1'b0; update_valid = 1'b0; lookup_valid = 1'b0;
        look(16'h0040);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b exp 0", hit); end
        checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b exp 0", taken); end
        checks++; if (target !== 16'h0000) begin errors++; $display("FAIL reset_target: got %h exp 0000", target); end
        checks++; if (lcnt !== 4'd0 || mcnt !== 4'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", lcnt, mcnt); end
        lookup_valid = 1'b1;
        tick();
        lookup_valid = 1'b0;
        checks++; if (lcnt !== 4'd1) begin errors++; $display("FAIL lookup_count_first: got %0d exp 1", lcnt); end
    endtask

    task automatic test_allocate();
        do_reset();
        upd(16'h0040, 1'b1, 16'h0010, 1'b0);
        look(16'h0040);
        checks++; if ({hit, taken, target} !== {1'b1, 1'b1, 16'h0010})
            begin errors++; $display("FAIL alloc_lookup: got %b%b %h exp 11 0010", hit, taken, target); end
        upd(16'h0080, 1'b0, 16'h0020, 1'b0);
        look(16'h0080);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nt_miss_no_alloc: got %b exp 0", hit); end
        look(16'h0040);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL nt_miss_keeps_entry: got %b exp 1", hit); end
    endtask

    task automatic test_saturation();
        look(16'h0040);
        repeat (3) upd(16'h0040, 1'b1, 16'h0010, 1'b1);
        upd(16'h0040, 1'b0, 16'h0000, 1'b1);
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL sat_after_1nt: got %b exp 1", taken); end
        upd(16'h0040, 1'b0, 16'h0000, 1'b1);
        checks++; if ({hit, taken} !== 2'b10) begin errors++; $display("FAIL sat_after_2nt: got %b%b exp 10", hit, taken); end
        upd(16'h0040, 1'b0, 16'h0000, 1'b0);
        upd(16'h0040, 1'b0, 16'h0000, 1'b0);
        upd(16'h0040, 1'b1, 16'h0022, 1'b0);
        checks++; if (taken !== 1'b0) begin errors++; $display("FAIL sat_floor_then_taken: got %b exp 0", taken); end
        checks++; if (target !== 16'h0022) begin errors++; $display("FAIL sat_target_update: got %h exp 0022", target); end
        upd(16'h0040, 1'b1, 16'h0022, 1'b0);
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL sat_recover: got %b exp 1", taken); end
    endtask

    task automatic test_aliasing();
        do_reset();
        upd(16'h0040, 1'b1, 16'h0010, 1'b0);
        look(16'h0060);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL alias_tag_miss: got %b exp 0", hit); end
        upd(16'h0060, 1'b1, 16'h0100, 1'b0);
        look(16'h0060);
        checks++; if ({hit, target} !== {1'b1, 16'h0100}) begin errors++; $display("FAIL alias_replace: got %b %h exp 1 0100", hit, target); end
        look(16'h0040);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL alias_evicted: got %b exp 0", hit); end
    endtask

    task automatic test_read_before_write();
        do_reset();
        upd(16'h0040, 1'b1, 16'h0010, 1'b0);
        upd(16'h0040, 1'b0, 16'h0000, 1'b0);
        update_valid = 1'b1; update_pc = 16'h0040; update_taken = 1'b1; update_target = 16'h0010;
        look(16'h0040);
        checks++; if ({hit, taken} !== 2'b10) begin errors++; $display("FAIL rbw_same_cycle: got %b%b exp 10", hit, taken); end
        tick();
        update_valid = 1'b0;
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL rbw_next_cycle: got %b exp 1", taken); end
    endtask

    task automatic test_stats();
        do_reset();
        lookup_valid = 1'b1;
        repeat (20) tick();
        checks++; if (lcnt !== 4'd15) begin errors++; $display("FAIL lookup_count_sat: got %0d exp 15", lcnt); end
        tick();
        lookup_valid = 1'b0;
        checks++; if (lcnt !== 4'd15) begin errors++; $display("FAIL lookup_count_hold: got %0d exp 15", lcnt); end
        repeat (3) upd(16'h0200, 1'b1, 16'h0300, 1'b0);
        checks++; if (mcnt !== 4'd3) begin errors++; $display("FAIL mispredict_3: got %0d exp 3", mcnt); end
        upd(16'h0200, 1'b1, 16'h0444, 1'b1);
        upd(16'h0400, 1'b0, 16'h0000, 1'b0);
        checks++; if (mcnt !== 4'd3) begin errors++; $display("FAIL mispredict_correct_ignored: got %0d exp 3", mcnt); end
        upd(16'h0400, 1'b0, 16'h0000, 1'b1);
        checks++; if (mcnt !== 4'd4) begin errors++; $display("FAIL mispredict_nt: got %0d exp 4", mcnt); end
    endtask

    task automatic test_mode0();
        do_reset();
        upd(16'h0040, 1'b1, 16'h0010, 1'b0);
        look(16'h0040);
        checks++; if ({m0_hit, m0_taken, m0_target} !== {1'b1, 1'b0, 16'h0010})
            begin errors++; $display("FAIL mode0_static: got %b%b %h exp 10 0010", m0_hit, m0_taken, m0_target); end
    endtask

    task automatic test_gshare();
        do_reset();
        // Two taken resolutions drive history to 2'b11; pc 0x0040 (raw index 0) then maps to entry 3.
        upd(16'h0002, 1'b1, 16'h0aaa, 1'b0);
        upd(16'h0002, 1'b1, 16'h0bbb, 1'b0);
        upd(16'h0040, 1'b1, 16'h0055, 1'b0);
        look(16'h0040);
        checks++; if ({g_hit, g_target} !== {1'b1, 16'h0055}) begin errors++; $display("FAIL ghr_hit: got %b %h exp 1 0055", g_hit, g_target); end
        upd(16'h0100, 1'b0, 16'h0000, 1'b0);
        look(16'h0040);
        checks++; if (g_hit !== 1'b0) begin errors++; $display("FAIL ghr_shifted_miss: got %b exp 0", g_hit); end
        look(16'h0042);
        checks++; if ({g_hit, g_target} !== {1'b1, 16'h0055}) begin errors++; $display("FAIL ghr_entry3: got %b %h exp 1 0055", g_hit, g_target); end
    endtask

    task automatic test_reset_mid_training();
        upd(16'h0040, 1'b1, 16'h0010, 1'b0);
        do_reset();
        look(16'h0040);
        checks++; if ({hit, target, mcnt} !== {1'b0, 16'h0000, 4'd0}) begin errors++; $display("FAIL reset_mid: got %b %h %0d exp 0 0000 0", hit, target, mcnt); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_aliasing();
        test_read_before_write();
        test_stats();
        test_mode0();
        test_gshare();
        test_reset_mid_training();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pmips_branch_predictor.md
Name: pmips_branch_predictor

Overview:
Parametrised dynamic branch predictor for the PMIPS pipeline. It is the successor to the fixed not-taken/PCSrc-at-MEM scheme. Indexed by the fetch PC, it returns a taken/not-taken prediction and a target from a direct-mapped BTB with per-entry saturating counters. It is trained by branch resolution from EX/MEM and optionally folds global history (gshare). Saturating statistics counters are exposed for debug.

Parameters:
ADDR_W, 16, PC/target width
ENTRIES, 16, BTB/counter entries; power of two, >=2; IDX_W = log2(ENTRIES)
INDEX_LSB, 1, lowest PC bit used for indexing (halfword instructions)
MODE, 2, 0 = static not-taken, 1 = one-bit, 2 = two-bit saturating
GHR_W, 0, global-history bits XORed into index; 0 = bimodal; must be <= IDX_W
CNT_W, 16, statistics counter width

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state at the next posedge
lookup_valid  in  1  fetch lookup qualifier (counted only)
lookup_pc  in  ADDR_W  current fetch PC
predict_hit  out  1  BTB entry valid and tag match
predict_taken  out  1  predicted taken
predict_target  out  ADDR_W  stored target; 0 when !predict_hit
update_valid  in  1  a branch resolved this cycle
update_pc  in  ADDR_W  PC of the resolved branch
update_taken  in  1  actual outcome
update_target  in  ADDR_W  actual branch target
update_predicted  in  1  predict_taken originally given for this branch
lookup_count  out  CNT_W  saturating count of lookup_valid cycles
mispredict_count  out  CNT_W  saturating count of updates where update_predicted != update_taken

Behaviour:
- Entry fields: valid, tag = pc[ADDR_W-1 : INDEX_LSB+IDX_W], target[ADDR_W], ctr[1:0].
- Index = pc[INDEX_LSB +: IDX_W] XOR {0, ghr[GHR_W-1:0]}. The same ghr value is used for lookup and update in a given cycle.
- Lookup is combinational from registered state (zero latency; same-cycle next-PC select):
  - predict_hit = valid & tag match.
  - predict_taken = predict_hit & ctr[1] in MODE 1/2; always 0 in MODE 0.
- Update is applied at the posedge when update_valid=1.
  - Hit, MODE 2: ctr saturating +1 if taken, -1 if not (11 and 00 hold). If taken, target <= update_target.
  - Hit, MODE 1: ctr <= taken ? 11 : 00. Target as above.
  - Hit, MODE 0: ctr unchanged. Target as above.
  - Miss and taken: allocate. valid=1, tag, target written; ctr = 10 (MODE 2) or 11 (MODE 0/1). The previous occupant is overwritten.
  - Miss and not-taken: no table change.
  - GHR_W>0: ghr <= {ghr[GHR_W-2:0], update_taken} (non-speculative, resolution only).
- Read-before-write: a lookup of the entry being updated in the same cycle returns the pre-update contents. The new contents are visible from the next cycle.
- Stats:
  - lookup_count +1 per cycle with lookup_valid.
  - mispredict_count +1 per update_valid with update_predicted != update_taken.
  - Both hold at 2^CNT_W-1.
  - Target mismatches with correct direction are not counted.
- Reset: all valid=0, ctr=01, target=0, ghr=0, both stats=0.
  - Outputs after reset: predict_hit=0, predict_taken=0, predict_target=0, counts=0.
  - An update or lookup coinciding with reset is discarded.
  - Reset asserted mid-training discards all learned state.
- No handshake back-pressure; the predictor accepts one lookup and one update every cycle.
- Target size: no reset fan-out beyond the listed state. RTL is expected to be 150-300 lines.

Test Plan:
1. Reset, then lookup_pc=0x0040 -> predict_hit=0, predict_taken=0, predict_target=0x0000, lookup_count counts from 0.
2. Allocation (MODE 2):
   - Stimulus: update pc=0x0040, taken=1, target=0x0010.
   - Response, next cycle: lookup 0x0040 -> hit=1, taken=1, target=0x0010.
   - Stimulus: not-taken update on miss pc=0x0080.
   - Response: lookup 0x0080 hit=0.
3. Saturation (MODE 2):
   - Stimulus: after allocation, 3 taken updates (ctr 11), then 1 not-taken.
   - Response: still taken (10).
   - Stimulus: 2nd not-taken.
   - Response: predict_taken=0 (01).
   - Stimulus: 3rd and 4th not-taken.
   - Response: ctr holds 00; a single taken update gives 01, still not-taken.
4. Aliasing (ENTRIES=16, INDEX_LSB=1):
   - Stimulus: 0x0040 allocated; lookup 0x0060 (same index 0).
   - Response: hit=0.
   - Stimulus: taken update 0x0060, target 0x0100.
   - Response: 0x0060 hit with target 0x0100; 0x0040 now hit=0.
5. Same-cycle update and lookup of 0x0040 (ctr 01 -> taken update) -> that cycle predict_taken=0; next cycle predict_taken=1.
6. Stats and mode variants:
   - CNT_W=4, 20 lookup_valid cycles -> lookup_count=15 and holds.
   - 3 updates with update_predicted=0, taken=1 -> mispredict_count=3.
   - MODE 0 after allocation -> hit=1, predict_taken=0.
   - GHR_W=2, after taken/taken history -> pc 0x0040 indexes entry 3.
